// File: rtl/board_b_d_gfx_arbiter_pkg.sv
// ============================================================================
// board_b_d_pkg : shared types and helpers for the M72-B-D gfx ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package board_b_d_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } gfx_src_t;

  // On a tie the side that was not served last wins.
  function automatic gfx_src_t rr_pick(input logic a_pend, input logic b_pend,
                                       input gfx_src_t last);
    if (a_pend && b_pend) return (last == SRC_A) ? SRC_B : SRC_A;
    return a_pend ? SRC_A : SRC_B;
  endfunction

  function automatic int cnt_width(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_b_d_gfx_arbiter_if.sv
// ============================================================================
// board_b_d_gfx_arbiter_if : layer A/B fetch ports plus gfx ROM read port
// Rev 1.0
// ============================================================================
`default_nettype none

interface board_b_d_gfx_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              a_rd;
  logic [ADDR_W-1:0] a_addr;
  logic              a_busy;
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              b_rd;
  logic [ADDR_W-1:0] b_addr;
  logic              b_busy;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              timeout_err;

  modport slave (
    input  a_rd, a_addr, b_rd, b_addr, mem_ack, mem_data,
    output a_busy, a_valid, a_data, b_busy, b_valid, b_data,
           mem_req, mem_addr, timeout_err
  );

  modport master (
    output a_rd, a_addr, b_rd, b_addr, mem_ack, mem_data,
    input  a_busy, a_valid, a_data, b_busy, b_valid, b_data,
           mem_req, mem_addr, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/board_b_d_gfx_arbiter_req_slot.sv
// ============================================================================
// board_b_d_req_slot : one-deep fetch request latch with data/valid outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module board_b_d_req_slot #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Clear only happens while busy, so a strobe can never collide with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_clear;
      if (i_clear) begin
        r_busy <= 1'b0;
        r_data <= i_data;
      end else if (i_rd && !r_busy) begin
        r_busy <= 1'b1;
        r_addr <= i_addr;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_addr  = r_addr;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/board_b_d_gfx_arbiter.sv
// ============================================================================
// board_b_d_gfx_arbiter : round-robin share of the gfx ROM port, layers A/B
// Rev 1.0
// ============================================================================
`default_nettype none

module board_b_d_gfx_arbiter
  import board_b_d_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          CLK_32M,
  input  logic                          RESET_N,
  board_b_d_gfx_arbiter_if.slave        bus
);

  localparam int         CNT_W  = cnt_width(TIMEOUT);
  localparam logic [1:0] S_IDLE = ARB_IDLE;
  localparam logic [1:0] S_REQ  = ARB_REQ;
  localparam logic [1:0] S_DONE = ARB_DONE;

  logic              w_a_busy, w_b_busy;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr;
  logic              w_a_clear, w_b_clear;
  gfx_src_t          w_pick;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_wd_fire;

  logic [1:0]        r_state;
  gfx_src_t          r_grant;
  gfx_src_t          r_last;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_toerr;

  board_b_d_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
    .clk(CLK_32M), .rst_n(RESET_N), .i_rd(bus.a_rd), .i_addr(bus.a_addr),
    .i_clear(w_a_clear), .i_data(r_rdata), .o_busy(w_a_busy),
    .o_addr(w_a_addr), .o_valid(bus.a_valid), .o_data(bus.a_data)
  );

  board_b_d_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
    .clk(CLK_32M), .rst_n(RESET_N), .i_rd(bus.b_rd), .i_addr(bus.b_addr),
    .i_clear(w_b_clear), .i_data(r_rdata), .o_busy(w_b_busy),
    .o_addr(w_b_addr), .o_valid(bus.b_valid), .o_data(bus.b_data)
  );

  assign w_a_clear = (r_state == S_DONE) && (r_grant == SRC_A);
  assign w_b_clear = (r_state == S_DONE) && (r_grant == SRC_B);
  assign w_pick    = rr_pick(w_a_busy, w_b_busy, r_last);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Fires on the cycle the count reaches TIMEOUT, so mem_req lasts TIMEOUT cycles.
  assign w_wd_fire = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_grant    <= SRC_A;
      r_last     <= SRC_B;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_toerr    <= 1'b0;
    end else begin
      r_toerr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_a_busy || w_b_busy) begin
            r_grant    <= w_pick;
            r_mem_req  <= 1'b1;
            r_mem_addr <= (w_pick == SRC_A) ? w_a_addr : w_b_addr;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            r_rdata   <= bus.mem_data;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_wd_fire) begin
            r_rdata   <= '0;
            r_mem_req <= 1'b0;
            r_toerr   <= 1'b1;
            r_state   <= S_DONE;
          end else if (TIMEOUT != 0) begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_last  <= r_grant;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_busy      = w_a_busy;
  assign bus.b_busy      = w_b_busy;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.timeout_err = r_toerr;

endmodule

`default_nettype wire

// File: tb/tb_board_b_d_gfx_arbiter.sv
// ============================================================================
// tb_board_b_d_gfx_arbiter : scoreboard bench for the gfx ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_board_b_d_gfx_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 8;

  logic CLK_32M = 1'b0;
  logic RESET_N = 1'b0;

  board_b_d_gfx_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  board_b_d_gfx_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK_32M(CLK_32M),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK_32M = ~CLK_32M;

  logic [DW-1:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  logic [AW-1:0] exp_g[$], got_g[$];
  int            got_len[$];
  logic [AW-1:0] hold_addr;
  int n_cmp = 0, n_bad = 0;
  int to_cnt = 0, unstable = 0, cur_len = 0, wcnt = 0;
  int mem_en = 1, ack_delay = 0;
  logic prev_req = 1'b0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 20'h12345) return 32'hDEADBEEF;
    return {a[11:0], a} ^ 32'h13579BDF;
  endfunction

  // One clock: observe outputs just after the edge, then drive memory response.
  task automatic tick();
    @(posedge CLK_32M);
    #1;
    if (RESET_N) begin
      if (bus.a_valid) got_a.push_back(bus.a_data);
      if (bus.b_valid) got_b.push_back(bus.b_data);
      if (bus.timeout_err) to_cnt++;
      if (bus.mem_req) begin
        if (!prev_req) begin
          got_g.push_back(bus.mem_addr);
          hold_addr = bus.mem_addr;
          cur_len = 0;
        end else if (bus.mem_addr !== hold_addr) unstable++;
        cur_len++;
      end else if (prev_req) got_len.push_back(cur_len);
    end
    prev_req = RESET_N ? bus.mem_req : 1'b0;
    bus.a_rd = 1'b0;
    bus.b_rd = 1'b0;
    bus.mem_ack = 1'b0;
    if (RESET_N && bus.mem_req) begin
      if (mem_en != 0 && wcnt == ack_delay) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem_fn(bus.mem_addr);
      end
      wcnt++;
    end else wcnt = 0;
  endtask

  task automatic clear_sb();
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
    exp_g.delete(); got_g.delete(); got_len.delete();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (got_a.size() >= exp_a.size() && got_b.size() >= exp_b.size() &&
          !bus.a_busy && !bus.b_busy && !bus.mem_req) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL %s_drain: got timeout waiting idle, want idle within 300 cycles", name);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) tick();
    n_cmp++;
    if ({bus.a_busy, bus.a_valid, bus.b_busy, bus.b_valid, bus.mem_req,
         bus.timeout_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000", {bus.a_busy, bus.a_valid,
               bus.b_busy, bus.b_valid, bus.mem_req, bus.timeout_err});
    end
    n_cmp++;
    if ({bus.a_data, bus.b_data, bus.mem_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {bus.a_data, bus.b_data, bus.mem_addr});
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_pair();
    clear_sb();
    for (int p = 0; p < 2; p++) begin
      logic [AW-1:0] aa, ba;
      aa = AW'(20'h00010 + 32 * p);
      ba = AW'(20'h00020 + 32 * p);
      bus.a_rd = 1'b1; bus.a_addr = aa;
      bus.b_rd = 1'b1; bus.b_addr = ba;
      exp_g.push_back(aa); exp_g.push_back(ba);
      exp_a.push_back(mem_fn(aa)); exp_b.push_back(mem_fn(ba));
      drain("pair");
    end
    n_cmp++;
    if (got_g.size() != exp_g.size()) begin
      n_bad++; $display("FAIL pair_grants: got %0d want %0d", got_g.size(), exp_g.size());
    end
    foreach (exp_g[i]) begin
      n_cmp++;
      if (i >= got_g.size() || got_g[i] !== exp_g[i]) begin
        n_bad++; $display("FAIL pair_order[%0d]: got %h want %h", i,
                          (i < got_g.size()) ? got_g[i] : 'x, exp_g[i]);
      end
    end
    foreach (exp_a[i]) begin
      n_cmp++;
      if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
        n_bad++; $display("FAIL pair_a_data[%0d]: want %h", i, exp_a[i]);
      end
    end
    foreach (exp_b[i]) begin
      n_cmp++;
      if (i >= got_b.size() || got_b[i] !== exp_b[i]) begin
        n_bad++; $display("FAIL pair_b_data[%0d]: want %h", i, exp_b[i]);
      end
    end
  endtask

  task automatic test_single();
    for (int d = 1; d >= 0; d--) begin
      int lat;
      clear_sb();
      ack_delay = d;
      lat = 0;
      bus.a_rd = 1'b1; bus.a_addr = 20'h12345;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        tick();
        if (k == 1) begin
          n_cmp++;
          if (bus.a_busy !== 1'b1) begin
            n_bad++; $display("FAIL single_busy: got %b want 1", bus.a_busy);
          end
        end
        if (bus.a_valid) lat = k;
      end
      n_cmp++;
      if (lat != 4 + d) begin
        n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, 4 + d);
      end
      n_cmp++;
      if (got_g.size() != 1 || got_g[0] !== 20'h12345) begin
        n_bad++; $display("FAIL single_addr: got %0d grants want one of 12345", got_g.size());
      end
      n_cmp++;
      if (got_a.size() != 1 || got_a[0] !== 32'hDEADBEEF || bus.a_data !== 32'hDEADBEEF) begin
        n_bad++; $display("FAIL single_data: got %h want deadbeef", bus.a_data);
      end
      for (int k = 0; k < 3; k++) tick();
      n_cmp++;
      if (got_b.size() != 0) begin
        n_bad++; $display("FAIL single_no_b: got %0d want 0 b_valid", got_b.size());
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_stream();
    int in_win, a_in_win, b_seen;
    logic [AW-1:0] na;
    clear_sb();
    in_win = 0; a_in_win = 0; b_seen = 0;
    na = 20'h20000;
    for (int c = 0; c < 60; c++) begin
      if (!bus.a_busy) begin
        bus.a_rd = 1'b1; bus.a_addr = na;
        exp_a.push_back(mem_fn(na)); na++;
      end
      if (c == 10) begin
        bus.b_rd = 1'b1; bus.b_addr = 20'h00777;
        exp_b.push_back(mem_fn(20'h00777));
        in_win = 1;
      end
      tick();
      if (in_win != 0 && bus.a_valid) a_in_win++;
      if (in_win != 0 && bus.b_valid) begin in_win = 0; b_seen = 1; end
    end
    drain("stream");
    n_cmp++;
    if (b_seen != 1 || a_in_win > 1) begin
      n_bad++; $display("FAIL stream_fair: got b_seen=%0d a_valids=%0d want 1 and <=1",
                        b_seen, a_in_win);
    end
    n_cmp++;
    if (got_a.size() != exp_a.size() || got_b.size() != 1) begin
      n_bad++; $display("FAIL stream_count: got %0d/%0d want %0d/1",
                        got_a.size(), got_b.size(), exp_a.size());
    end
    foreach (exp_a[i]) begin
      n_cmp++;
      if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
        n_bad++; $display("FAIL stream_a_data[%0d]: want %h", i, exp_a[i]);
      end
    end
    n_cmp++;
    if (got_b.size() < 1 || got_b[0] !== exp_b[0]) begin
      n_bad++; $display("FAIL stream_b_data: want %h", exp_b[0]);
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++; $display("FAIL addr_stable: got %0d changes want 0", unstable);
    end
  endtask

  task automatic test_timeout(input int en, input int dly, input string name);
    int base;
    logic [DW-1:0] want;
    clear_sb();
    mem_en = en; ack_delay = dly;
    base = to_cnt;
    want = (en != 0) ? mem_fn(20'h0ABCD) : '0;
    bus.a_rd = 1'b1; bus.a_addr = 20'h0ABCD;
    exp_a.push_back(want);
    drain(name);
    n_cmp++;
    if (got_len.size() != 1 || got_len[0] != TO) begin
      n_bad++; $display("FAIL %s_req_len: got %0d want %0d", name,
                        (got_len.size() > 0) ? got_len[0] : -1, TO);
    end
    n_cmp++;
    if (to_cnt - base != ((en != 0) ? 0 : 1)) begin
      n_bad++; $display("FAIL %s_err_pulses: got %0d want %0d", name, to_cnt - base,
                        (en != 0) ? 0 : 1);
    end
    n_cmp++;
    if (got_a.size() != 1 || got_a[0] !== want || got_b.size() != 0) begin
      n_bad++; $display("FAIL %s_data: got %h want %h", name, bus.a_data, want);
    end
    mem_en = 1; ack_delay = 0;
  endtask

  task automatic test_busy_ignore();
    int seen;
    clear_sb();
    ack_delay = 2;
    bus.a_rd = 1'b1; bus.a_addr = 20'h01111;
    exp_g.push_back(20'h01111); exp_a.push_back(mem_fn(20'h01111));
    tick();
    bus.a_rd = 1'b1; bus.a_addr = 20'h02222;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      tick();
      if (bus.a_valid) seen = 1;
    end
    bus.a_rd = 1'b1; bus.a_addr = 20'h03333;
    exp_g.push_back(20'h03333); exp_a.push_back(mem_fn(20'h03333));
    tick();
    n_cmp++;
    if (bus.a_busy !== 1'b1) begin
      n_bad++; $display("FAIL valid_cycle_accept: got busy %b want 1", bus.a_busy);
    end
    drain("busy");
    foreach (exp_g[i]) begin
      n_cmp++;
      if (i >= got_g.size() || got_g[i] !== exp_g[i]) begin
        n_bad++; $display("FAIL busy_addr[%0d]: got %h want %h", i,
                          (i < got_g.size()) ? got_g[i] : 'x, exp_g[i]);
      end
    end
    n_cmp++;
    if (got_a.size() != 2 || got_a[1] !== exp_a[1] || got_a[0] !== exp_a[0]) begin
      n_bad++; $display("FAIL busy_data: got %0d words want 2", got_a.size());
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    int hit;
    clear_sb();
    mem_en = 0;
    hit = 0;
    bus.b_rd = 1'b1; bus.b_addr = 20'h05555;
    for (int k = 0; k < 20 && hit == 0; k++) begin
      tick();
      if (bus.mem_req) hit = 1;
    end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (hit != 1 || {bus.mem_req, bus.a_busy, bus.b_busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_mid: got req/busy %b want 000",
                        {bus.mem_req, bus.a_busy, bus.b_busy});
    end
    tick(); tick();
    RESET_N = 1'b1;
    mem_en = 1;
    clear_sb();
    tick();
    bus.mem_ack = 1'b1; bus.mem_data = 32'hCAFEF00D;
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if (got_a.size() + got_b.size() + got_g.size() != 0) begin
      n_bad++; $display("FAIL late_ack: got %0d valids %0d grants want 0",
                        got_a.size() + got_b.size(), got_g.size());
    end
  endtask

  initial begin
    bus.a_rd = 1'b0; bus.a_addr = '0;
    bus.b_rd = 1'b0; bus.b_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_data = '0;
    test_reset();
    test_pair();
    test_single();
    test_stream();
    test_timeout(0, 0, "timeout");
    test_timeout(1, TO - 1, "ack_at_limit");
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
